// File: rtl/fifo_pkg.sv
// Shared sizing, types and helpers for the frame FIFO between the ADC sample path
// and the SPI readout.
package fifo_pkg;

    localparam int DEPTH   = 16;
    localparam int WORDS   = 8;
    localparam int WIDTH   = 16;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SEL_W   = $clog2(WORDS);
    localparam int THR_W   = 4;
    localparam int FRAME_W = WORDS * WIDTH;

    typedef logic [WORDS-1:0][WIDTH-1:0] frame_t;

    // A programmed threshold of zero behaves as one frame.
    function automatic logic [CNT_W-1:0] eff_threshold(input logic [THR_W-1:0] thr);
        return (thr == '0) ? CNT_W'(1) : CNT_W'(thr);
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector that emits a single-cycle pulse per request.
module pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/dual_clock_fifo.sv
// Frame FIFO: assembles 8-word frames, stores up to 16 of them and presents the
// oldest one as a flat word, with a programmable readiness threshold.
module dual_clock_fifo
    import fifo_pkg::*;
(
    input  logic               sample_clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               done,
    input  logic               last_word,
    input  logic [SEL_W-1:0]   atmchsel,
    input  logic [THR_W-1:0]   threshold,
    input  logic               frame_pop,
    output logic               fifo_ready,
    output logic [FRAME_W-1:0] frame_data_out
);

    frame_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic pop_pulse;
    logic full;
    logic wr_en;
    logic commit;
    logic pop;
    logic scrub_next;
    logic scrub_read;

    pulse_sync u_pop_sync (
        .clk      (sample_clk),
        .rst_n    (reset_n),
        .async_in (frame_pop),
        .pulse    (pop_pulse)
    );

    // The full test deliberately uses the pre-pop count.
    assign full    = (count == CNT_W'(DEPTH));
    assign wr_en   = done & ~full;
    assign commit  = wr_en & last_word;
    assign pop     = pop_pulse & (count != '0);
    assign wr_next = wr_ptr + 1'b1;

    // NOTE: every signal assigned in always_comb receives a default first, so no
    // path can leave it holding a value and infer a latch.
    always_comb begin
        count_next = count;
        case ({commit, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // A slot is zeroed at the moment it becomes the free write slot.
    assign scrub_next = commit & (count_next != CNT_W'(DEPTH));
    assign scrub_read = pop & full;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit) wr_ptr <= wr_next;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // NOTE: the frame store is reset because unwritten words of every frame must
    // read as zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            mem <= '{default: '0};
        end else begin
            if (wr_en)      mem[wr_ptr][atmchsel] <= data_in;
            if (scrub_next) mem[wr_next]          <= '0;
            if (scrub_read) mem[rd_ptr]           <= '0;
        end
    end

    assign frame_data_out = (count != '0) ? FRAME_W'(mem[rd_ptr]) : '0;
    assign fifo_ready     = (count >= eff_threshold(threshold));

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Self-checking bench for dual_clock_fifo: directed sequences plus randomized
// traffic compared against a queue-based frame model.
module tb_dual_clock_fifo;

    logic         sample_clk = 1'b0;
    logic         reset_n;
    logic [15:0]  data_in;
    logic         done;
    logic         last_word;
    logic [2:0]   atmchsel;
    logic [3:0]   threshold;
    logic         frame_pop;
    logic         fifo_ready;
    logic [127:0] frame_data_out;

    int n_vec = 0;
    int n_err = 0;

    dual_clock_fifo dut (
        .sample_clk     (sample_clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .done           (done),
        .last_word      (last_word),
        .atmchsel       (atmchsel),
        .threshold      (threshold),
        .frame_pop      (frame_pop),
        .fifo_ready     (fifo_ready),
        .frame_data_out (frame_data_out)
    );

    always #5 sample_clk = ~sample_clk;

    // Reference model: committed frames in order, the frame being assembled,
    // and a countdown to the edge at which a pop request takes effect.
    logic [127:0] q[$];
    logic [15:0]  cur[8];
    int           pop_cnt;

    typedef struct {
        logic [3:0] thr;
        logic       exp_ready;
    } thr_vec_t;

    thr_vec_t tv[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready();
        int thr;
        thr = (threshold == 4'd0) ? 1 : int'(threshold);
        return (q.size() >= thr);
    endfunction

    function automatic logic [127:0] exp_frame();
        return (q.size() == 0) ? 128'h0 : q[0];
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 8; k++) cur[k] = 16'h0;
        pop_cnt = 0;
    endtask

    task automatic model_edge(input logic d, input logic l, input logic [2:0] s, input logic [15:0] v);
        int           pre;
        logic         fire;
        logic [127:0] f;
        pre  = q.size();
        fire = 1'b0;
        if (pop_cnt > 0) begin
            pop_cnt--;
            fire = (pop_cnt == 0);
        end
        if (d && pre < 16) begin
            cur[s] = v;
            if (l) begin
                f = '0;
                for (int k = 0; k < 8; k++) f[16*k +: 16] = cur[k];
                q.push_back(f);
                for (int k = 0; k < 8; k++) cur[k] = 16'h0;
            end
        end
        if (fire && pre > 0) void'(q.pop_front());
    endtask

    // Called at a falling edge: drive, clock, then compare at the next falling edge.
    task automatic step(input logic d, input logic l, input logic [2:0] s, input logic [15:0] v, input logic p);
        done      = d;
        last_word = l;
        atmchsel  = s;
        data_in   = v;
        if (p && !frame_pop) pop_cnt = 3;
        frame_pop = p;
        @(posedge sample_clk);
        model_edge(d, l, s, v);
        @(negedge sample_clk);
        check("ready", 128'(fifo_ready), 128'(exp_ready()));
        check("frame", frame_data_out, exp_frame());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic write_frame(input int f);
        for (int w = 0; w < 8; w++)
            step(1'b1, (w == 7), 3'(w), 16'((f << 8) | w), 1'b0);
    endtask

    task automatic pop_frame();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) idle();
    endtask

    initial begin
        int hi_left;
        int lo_left;
        int last_pct;
        logic d;
        logic l;
        logic p;

        tv[0] = '{4'd0,  1'b1};
        tv[1] = '{4'd1,  1'b1};
        tv[2] = '{4'd4,  1'b1};
        tv[3] = '{4'd5,  1'b0};
        tv[4] = '{4'd8,  1'b0};
        tv[5] = '{4'd15, 1'b0};

        model_reset();
        reset_n   = 1'b0;
        data_in   = 16'h0;
        done      = 1'b0;
        last_word = 1'b0;
        atmchsel  = 3'd0;
        threshold = 4'd8;
        frame_pop = 1'b0;
        repeat (2) @(negedge sample_clk);
        check("reset_ready", 128'(fifo_ready), 128'h0);
        check("reset_frame", frame_data_out, 128'h0);
        reset_n = 1'b1;

        // Idle with threshold 8.
        repeat (10) idle();
        check("idle_ready", 128'(fifo_ready), 128'h0);

        // Back-to-back fill of four frames.
        for (int f = 0; f < 4; f++) write_frame(f);
        check("fill_word0", 128'(frame_data_out[15:0]), 128'h0000);
        check("fill_word7", 128'(frame_data_out[127:112]), 128'h0007);
        for (int i = 0; i < 6; i++) begin
            threshold = tv[i].thr;
            #1;
            check($sformatf("thr_%0d", tv[i].thr), 128'(fifo_ready), 128'(tv[i].exp_ready));
            idle();
        end

        // Partial frame closed on word 1.
        step(1'b1, 1'b0, 3'd0, 16'h55AA, 1'b0);
        step(1'b1, 1'b1, 3'd1, 16'h55AA, 1'b0);
        threshold = 4'd5;
        #1;
        check("thr5_same_cycle", 128'(fifo_ready), 128'h1);
        idle();

        // Overflow: twelve single-word commits, only eleven fit.
        threshold = 4'd15;
        repeat (12) step(1'b1, 1'b1, 3'd0, 16'hEEEE, 1'b0);
        check("full_ready", 128'(fifo_ready), 128'h1);
        check("full_oldest_word0", 128'(frame_data_out[15:0]), 128'h0000);
        check("full_oldest_word1", 128'(frame_data_out[31:16]), 128'h0001);

        // First pop happens while full; it must land on the third edge.
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        check("pop_edge2_word1", 128'(frame_data_out[31:16]), 128'h0001);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        check("pop_edge3_word1", 128'(frame_data_out[31:16]), 128'h0101);
        repeat (3) idle();

        // Commit into the slot freed by the full-state pop.
        step(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0);
        repeat (3) pop_frame();
        check("partial_frame", frame_data_out, 128'h55AA55AA);

        // Commit and pop on the same edge: count stays at 13.
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 3'd2, 16'hC0DE, 1'b1);
        repeat (3) idle();
        threshold = 4'd13;
        #1;
        check("simul_thr13", 128'(fifo_ready), 128'h1);
        idle();
        threshold = 4'd14;
        #1;
        check("simul_thr14", 128'(fifo_ready), 128'h0);
        idle();

        // Drain, then pop once more while empty.
        repeat (13) pop_frame();
        pop_frame();
        threshold = 4'd0;
        #1;
        check("empty_pop_ready", 128'(fifo_ready), 128'h0);
        check("empty_pop_frame", frame_data_out, 128'h0);
        idle();

        // Reset in the middle of a frame clears immediately.
        write_frame(5);
        step(1'b1, 1'b0, 3'd2, 16'hABCD, 1'b0);
        threshold = 4'd1;
        #1;
        check("pre_reset_ready", 128'(fifo_ready), 128'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_ready", 128'(fifo_ready), 128'h0);
        check("midreset_frame", frame_data_out, 128'h0);
        model_reset();
        done      = 1'b0;
        last_word = 1'b0;
        @(negedge sample_clk);
        reset_n = 1'b1;
        idle();

        // Randomized traffic: a commit-heavy phase, then a drain-heavy phase.
        hi_left = 0;
        lo_left = 3;
        for (int c = 0; c < 3000; c++) begin
            last_pct = (c < 1500) ? 35 : 6;
            if ($urandom_range(15) == 0) threshold = 4'($urandom_range(15));
            d = ($urandom_range(99) < 60);
            l = ($urandom_range(99) < last_pct);
            if (hi_left > 0) begin
                p = 1'b1;
                hi_left--;
                if (hi_left == 0) lo_left = 2 + $urandom_range(2);
            end else begin
                p = 1'b0;
                if (lo_left > 0) lo_left--;
                else if ($urandom_range(3) == 0) hi_left = 1 + $urandom_range(2);
            end
            step(d, l, 3'($urandom_range(7)), 16'($urandom), p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
